// File: rtl/spi_rx.sv
// SPI receiver: oversamples spi_cs/spi_clk/spi_data, assembles MSB-first words, hands them out on valid/ready.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise a single holding register is used.
module spi_rx #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              spi_cs,
  input  logic              spi_clk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  logic [2:0]        cs_q;
  logic [2:0]        sclk_q;
  logic [1:0]        data_q;
  logic              cs_rise;
  logic              cs_fall;
  logic              sclk_rise;
  logic              data_s;

  logic [1:0]        state;
  logic [1:0]        st_eff;
  logic [1:0]        state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic [DATA_W-1:0] shreg;
  logic              shift_en;
  logic              err_nx;
  logic              push_nx;
  logic              push_pend;
  logic              pop;

  // cs idles high, so its synchroniser resets high to avoid a false fall after reset
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cs_q   <= 3'b111;
      sclk_q <= 3'b000;
      data_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], spi_cs};
      sclk_q <= {sclk_q[1:0], spi_clk};
      data_q <= {data_q[0], spi_data};
    end
  end

  assign cs_rise   =  cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] &  cs_q[2];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign data_s    =  data_q[1];

  // The shift of this clk is folded into st_eff before a coincident cs rise is judged
  always_comb begin
    shift_en = (state != ST_IDLE) && sclk_rise;
    cnt_nx   = cnt;
    if (shift_en && (cnt != CNT_SAT))
      cnt_nx = cnt + 1'b1;

    st_eff = state;
    if ((state == ST_SHIFT) && (cnt_nx >= CNT_FULL))
      st_eff = ST_FULL;
    else if ((state == ST_FULL) && shift_en)
      st_eff = ST_OVER;

    state_nx = st_eff;
    err_nx   = 1'b0;
    push_nx  = 1'b0;
    case (st_eff)
      ST_IDLE:  if (cs_fall) state_nx = ST_SHIFT;
      ST_SHIFT: if (cs_rise) begin state_nx = ST_IDLE; err_nx  = 1'b1; end
      ST_FULL:  if (cs_rise) begin state_nx = ST_IDLE; push_nx = 1'b1; end
      ST_OVER:  if (cs_rise) begin state_nx = ST_IDLE; err_nx  = 1'b1; end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      push_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_err <= err_nx;
      push_pend <= push_nx;
      if ((state == ST_IDLE) && cs_fall)
        cnt <= '0;
      else
        cnt <= cnt_nx;
      if (shift_en)
        shreg <= {shreg[DATA_W-2:0], data_s};
    end
  end

  assign pop = rx_valid && rx_ready;

`ifdef SPI_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              empty;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign rx_valid = !empty;
  assign rx_data  = mem[rd_ptr[AW-1:0]];

  // When full, a same-clk pop frees the head slot, which is exactly where the new word lands
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      overrun <= push_pend && full && !pop;
      if (push_pend && (!full || pop)) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= push_pend && rx_valid && !rx_ready;
      if (push_pend && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (pop) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: table vectors, hand-written corner sequences and a randomized frame-level model.
`timescale 1ns/1ps
module tb_spi_rx;

  localparam int DATA_W = 24;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [23:0] exp_word;
    logic        exp_err;
  } vec_t;

  logic              clk      = 1'b0;
  logic              RSTn     = 1'b0;
  logic              spi_cs   = 1'b1;
  logic              spi_clk  = 1'b0;
  logic              spi_data = 1'b0;
  logic              rx_ready = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              overrun;

  int n_vectors     = 0;
  int n_miscompares = 0;
  int fe_cnt        = 0;
  int ov_cnt        = 0;
  logic [DATA_W-1:0] got_q[$];
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always #5 clk = ~clk;

  spi_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .RSTn     (RSTn),
    .spi_cs   (spi_cs),
    .spi_clk  (spi_clk),
    .spi_data (spi_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change 2ns after a rising edge; outputs are sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic sendBits(input logic [31:0] bits, input int nbits, input int abort_after);
    spi_cs = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      if ((abort_after >= 0) && ((nbits - 1 - i) == abort_after)) return;
      spi_data = bits[i];
      tick(4);
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
    end
    tick(4);
    spi_cs = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    sendBits(v.bits, v.nbits, -1);
    tick(12);
  endtask

  task automatic waitWords(input int n, input string name);
    int t = 0;
    while ((got_q.size() < n) && (t < 200)) begin
      tick(1);
      t++;
    end
    if (got_q.size() < n) checkOutput({name, "_timeout"}, got_q.size(), n);
  endtask

  // Consumer-side monitor: records accepted words, counts pulses, checks hold-while-stalled
  always @(negedge clk) begin
    if (!RSTn) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checkOutput("hold_valid", rx_valid, 1);
        checkOutput("hold_data", rx_data, prev_data);
      end
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[8];
    vec_t        v;
    int          fe_base;
    int          ov_base;
    logic [23:0] words[5];
    logic [23:0] exp_q[$];
    int          exp_err;
    logic [31:0] w;
    int          nb;

    vecs[0] = '{32'h0028bb85, 24, 24'h28bb85, 1'b0};
    vecs[1] = '{32'h00000fff, 24, 24'h000fff, 1'b0};
    vecs[2] = '{32'h00555555, 24, 24'h555555, 1'b0};
    vecs[3] = '{32'h00123456, 24, 24'h123456, 1'b0};
    vecs[4] = '{32'h000abcde, 20, 24'h000000, 1'b1};
    vecs[5] = '{32'h01abcdef, 25, 24'h000000, 1'b1};
    vecs[6] = '{32'h00abcdef, 24, 24'habcdef, 1'b0};
    vecs[7] = '{32'hff000001,  1, 24'h000000, 1'b1};

    // Reset state
    tick(3);
    @(negedge clk);
    checkOutput("reset_valid", rx_valid, 0);
    checkOutput("reset_data", rx_data, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_overrun", overrun, 0);
    tick(1);
    RSTn = 1'b1;
    tick(4);

    // Table-driven single frames, consumer always ready
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      got_q.delete();
      fe_base = fe_cnt;
      ov_base = ov_cnt;
      applyStimulus(v);
      if (!v.exp_err) begin
        waitWords(1, $sformatf("vec%0d", i));
        if (got_q.size() > 0) checkOutput($sformatf("vec%0d_word", i), got_q.pop_front(), v.exp_word);
      end
      checkOutput($sformatf("vec%0d_extra_words", i), got_q.size(), 0);
      checkOutput($sformatf("vec%0d_frame_err", i), fe_cnt - fe_base, v.exp_err ? 1 : 0);
      checkOutput($sformatf("vec%0d_overrun", i), ov_cnt - ov_base, 0);
    end

    // Back-to-back frames with minimum cs gap
    words = '{24'h000fff, 24'h555555, 24'h123456, 24'h28bb85, 24'h000000};
    got_q.delete();
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    for (int i = 0; i < 4; i++) begin
      sendBits({8'h00, words[i]}, 24, -1);
      tick(3);
    end
    waitWords(4, "b2b");
    for (int i = 0; i < 4; i++)
      if (got_q.size() > 0) checkOutput($sformatf("b2b_word%0d", i), got_q.pop_front(), words[i]);
    checkOutput("b2b_overrun", ov_cnt - ov_base, 0);
    checkOutput("b2b_frame_err", fe_cnt - fe_base, 0);

    // Stalled consumer: CAP+1 frames give exactly one overrun, then drain in order
    words = '{24'hA00001, 24'hB00002, 24'hC00003, 24'hD00004, 24'hE00005};
    rx_ready = 1'b0;
    tick(4);
    got_q.delete();
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    for (int i = 0; i <= CAP; i++) begin
      sendBits({8'h00, words[i]}, 24, -1);
      tick(6);
    end
    tick(6);
    checkOutput("stall_overrun", ov_cnt - ov_base, 1);
    checkOutput("stall_words_before_drain", got_q.size(), 0);
    rx_ready = 1'b1;
    waitWords(CAP, "drain");
    tick(6);
    checkOutput("drain_count", got_q.size(), CAP);
    for (int i = 0; i < CAP; i++)
      if (got_q.size() > 0) checkOutput($sformatf("drain_word%0d", i), got_q.pop_front(), words[i]);
    checkOutput("stall_frame_err", fe_cnt - fe_base, 0);

    // Pop and push of a full buffer in (or around) the same clk
    for (int k = 1; k <= 3; k++) begin
      rx_ready = 1'b0;
      tick(4);
      got_q.delete();
      ov_base = ov_cnt;
      for (int i = 0; i < CAP; i++) begin
        sendBits({8'h00, words[i]}, 24, -1);
        tick(6);
      end
      sendBits({8'h00, words[4]}, 24, -1);
      tick(k);
      rx_ready = 1'b1;
      waitWords(CAP + 1, $sformatf("popush%0d", k));
      tick(6);
      checkOutput($sformatf("popush%0d_overrun", k), ov_cnt - ov_base, 0);
      for (int i = 0; i < CAP; i++)
        if (got_q.size() > 0) checkOutput($sformatf("popush%0d_word%0d", k, i), got_q.pop_front(), words[i]);
      if (got_q.size() > 0) checkOutput($sformatf("popush%0d_last", k), got_q.pop_front(), words[4]);
    end

    // Reset in the middle of a frame while a word is buffered
    rx_ready = 1'b0;
    tick(4);
    sendBits(32'h0013579b, 24, -1);
    tick(10);
    @(negedge clk);
    checkOutput("pre_reset_valid", rx_valid, 1);
    tick(1);
    fe_base = fe_cnt;
    sendBits(32'h00ffffff, 24, 12);
    RSTn    = 1'b0;
    spi_cs  = 1'b1;
    spi_clk = 1'b0;
    tick(2);
    @(negedge clk);
    checkOutput("midreset_valid", rx_valid, 0);
    checkOutput("midreset_data", rx_data, 0);
    checkOutput("midreset_frame_err", frame_err, 0);
    checkOutput("midreset_overrun", overrun, 0);
    tick(1);
    RSTn = 1'b1;
    got_q.delete();
    tick(4);
    rx_ready = 1'b1;
    sendBits(32'h00555555, 24, -1);
    waitWords(1, "postreset");
    if (got_q.size() > 0) checkOutput("postreset_word", got_q.pop_front(), 24'h555555);
    tick(6);
    checkOutput("postreset_frame_err", fe_cnt - fe_base, 0);

    // Randomized frames against a frame-level model
    got_q.delete();
    exp_q.delete();
    exp_err = 0;
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    for (int i = 0; i < 12; i++) begin
      w  = $urandom;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 24;
      sendBits(w, nb, -1);
      tick(8);
      if (nb == DATA_W) exp_q.push_back(w[23:0]);
      else exp_err++;
    end
    tick(10);
    checkOutput("rand_count", got_q.size(), exp_q.size());
    while ((got_q.size() > 0) && (exp_q.size() > 0))
      checkOutput("rand_word", got_q.pop_front(), exp_q.pop_front());
    checkOutput("rand_frame_err", fe_cnt - fe_base, exp_err);
    checkOutput("rand_overrun", ov_cnt - ov_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
